// File: rtl/serial_arith_pkg.sv
// Shared definitions for the digit-serial add/sub datapath: FSM encodings,
// mode constants and counter sizing.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // Digit counter width; never below one bit so N=1 still has a legal counter.
   function automatic int unsigned cnt_width(input int unsigned width,
                                             input int unsigned digit);
      int unsigned n;
      n = width / digit;
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit combinational ripple adder; also exposes the carry into the digit
// MSB so the caller can derive two's-complement overflow.
module digit_adder #(
   parameter int unsigned DIGIT = 2
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb_in
);

   logic [DIGIT:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout     = c[DIGIT];
   assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial WIDTH-bit adder/subtractor: DIGIT bits per cycle, start/busy/done
// handshake, carry and signed-overflow flags.
module serial_add_sub
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = cnt_width(WIDTH, DIGIT);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [DIGIT-1:0]       dsum;
   logic                   dcout, dc_msb_in;
   logic [WIDTH+DIGIT-1:0] acc_cat;
   logic [WIDTH-1:0]       acc_shift;
   logic                   last;

   digit_adder #(
      .DIGIT(DIGIT)
   ) u_digit_adder (
      .a       (opa_q[DIGIT-1:0]),
      .b       (opb_q[DIGIT-1:0]),
      .cin     (carry_q),
      .sum     (dsum),
      .cout    (dcout),
      .c_msb_in(dc_msb_in)
   );

   // New digit enters at the MSB end; after N digits the LSB digit sits at bit 0.
   assign acc_cat   = {dsum, acc_q};
   assign acc_shift = WIDTH'(acc_cat >> DIGIT);
   assign last      = (cnt_q == CW'(N - 1));

   always_comb begin
      state_d  = state_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               // Subtract as a + ~b + ~borrow.
               opa_d   = a;
               opb_d   = (mode == MODE_SUB) ? ~b : b;
               carry_d = (mode == MODE_SUB) ? ~cin : cin;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            opa_d   = opa_q >> DIGIT;
            opb_d   = opb_q >> DIGIT;
            acc_d   = acc_shift;
            carry_d = dcout;
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
               result_d = acc_shift;
               cout_d   = dcout;
               ovf_d    = dc_msb_in ^ dcout;
               state_d  = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         opa_q    <= '0;
         opb_q    <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign result   = result_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;

endmodule
